// File: rtl/wb_host_master_if.sv
// Host request/response port plus Wishbone classic master signals.
// The master modport is the wb_host_master view; slave is the harness/slave side.
interface wb_host_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SEL_W-1:0]  req_sel;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
           wb_data_i, wb_ack_i, wb_err_i,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_sel, rsp_ready,
           wb_data_i, wb_ack_i, wb_err_i,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );
endinterface

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic (B3) master: one valid/ready request
// becomes one single-beat bus cycle, with a watchdog against silent slaves.
module wb_host_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMR_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  wb_host_master_if.master  bus
);
  localparam int unsigned SEL_W = DATA_W / 8;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              done_c;
  logic              expire_c;

  assign done_c   = bus.wb_ack_i | bus.wb_err_i;
  assign expire_c = WD_EN && (timer_q == TMR_LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid)         state_d = BUS;
      BUS:     if (done_c || expire_c)    state_d = RESP;
      RESP:    if (bus.rsp_ready)         state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and watchdog
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cyc_d       = 1'b1;
          we_d        = bus.req_we;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          sel_d       = bus.req_sel;
          req_ready_d = 1'b0;
          timer_d     = '0;
        end
      end
      BUS: begin
        if (done_c) begin
          // Error wins over a simultaneous ack; only clean read acks carry data.
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.wb_err_i;
          rsp_data_d  = (!we_q && bus.wb_ack_i && !bus.wb_err_i) ? bus.wb_data_i : '0;
        end else if (expire_c) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          req_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_addr_o = addr_q;
  assign bus.wb_data_o = wdata_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
